vga_sprite_engine: RTL and testbench
====================================

# vga_sprite_engine

Parametrised successor to the single-ball/two-paddle display: drives a VGA monitor with NUM_OBJ generic rectangular objects plus a fixed playfield border. The CPU writes per-object position, size, colour and enable into shadow registers over the peripheral bus; shadows commit to the active set once per frame, so objects never tear. Sits between the arcade CPU bus and the VGA connector, replacing the fixed-object display.

## Interface
- NUM_OBJ, 8: object count, 1..16; lower index has higher draw priority
- COORD_W, 10: coordinate width in bits
- H_ACTIVE / H_FRONT / H_SYNC / H_BACK, 640/16/96/48: horizontal timing in pixels
- V_ACTIVE / V_FRONT / V_SYNC / V_BACK, 480/10/2/33: vertical timing in lines
- BORDER, 10: playfield border thickness in pixels; 0 disables the border
- BORDER_RGB, 8'b011_011_01: border colour {r,g,b}
- clk  in  1  pixel clock (25 MHz for defaults)
- rst  in  1  synchronous, active-high reset
- sel  in  1  bus select
- we  in  1  write strobe, qualified by sel
- addr  in  $clog2(NUM_OBJ)+2  {object index, field[1:0]}
- wdata  in  16  write data
- rdata  out  16  read data, registered
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low
- red  out  3; green  out  3; blue  out  2  pixel colour
- frame_start  out  1  one-cycle pulse on the commit cycle
- coll_status  out  NUM_OBJ  per-object collision flags from the previous frame

## Operation
- Fields: 0 = x[COORD_W-1:0]; 1 = y[COORD_W-1:0]; 2 = {h[15:8], w[7:0]}; 3 = {en[8], rgb[7:0]}. Unused wdata bits are ignored and read back as 0.
- Write: on sel&&we, wdata updates the addressed shadow field. Writes to object indices >= NUM_OBJ are dropped.
- Read: on sel&&!we, rdata carries the shadow field on the next cycle; rdata otherwise holds its last value. Reads of out-of-range objects return 0.
- Commit: on the cycle where the counters are at (H_ACTIVE-1, V_ACTIVE-1), all shadows copy into the active set and frame_start pulses.
  - A write on the commit cycle reaches the shadow only; it appears one frame later.
- Timing generator: h_cnt wraps 0..H_TOTAL-1; v_cnt advances on each h wrap and wraps 0..V_TOTAL-1. HS is low during the H_SYNC window after H_ACTIVE+H_FRONT; VS follows the same rule per line.
- Hit test: h_cnt >= x && h_cnt < x+w, and likewise for y/h.
  - Comparisons use COORD_W+1 bits, so the sum never wraps.
  - w=0, h=0 or en=0 never hits.
  - Objects running past the active area are clipped.
- Colour priority: lowest-index hit object, then border (h or v within BORDER of any active edge), then black. Outside the active area the output is black.

## Timing
- Reset values: counters 0, all shadow and active registers 0, rdata 0, HS=VS=1, rgb 0, frame_start 0, coll_status 0.
- Reset mid-frame restarts at (0,0) on the next cycle, with no partial sync pulse.
- Pixel pipeline is 2 stages. Stage 1 registers the hit vector, border flag and active flag. Stage 2 registers the colour mux.
- HS/VS are delayed 2 cycles to align with rgb.
- Bus latency: write takes effect in the shadow after 1 cycle; read data is valid after 1 cycle.

## Configuration
- VGA_SPRITE_COLLISION_EN defined:
  - Each object's flag sets when its stage-1 hit coincides with any other object's hit during active display.
  - Flags transfer to coll_status at commit, then clear for the next frame.
- Undefined: no collision logic is built and coll_status is tied to 0.

## Structure
- Package vga_sprite_pkg holds the field index constants (FLD_X, FLD_Y, FLD_SIZE, FLD_CTRL), the object record typedef {x, y, w, h, en, rgb}, and the default timing constants.
- Sub-module vga_timing_gen contains the h/v counters, sync generation, active flag and commit strobe, with all timing parameters passed through.

## Test plan
- Reset, then run one frame: HS period is 800 clocks with 96 low; VS period is 525 lines with 2 low; the first frame_start arrives 480×800−... cycles at (639,479).
- Write obj0 x=100, y=50, w=10, h=10, en, rgb=8'hE0 mid-frame: pixels stay black this frame; next frame (100..109, 50..59) outputs red 3'b111, 2 cycles after the counters.
- Overlap obj1 (rgb 8'h03) with obj0 at the same origin: obj0's colour wins. With the macro, coll_status=2'b11 after the following commit.
- Set w=250 at x=600: the object is clipped at 639 and nothing wraps to x=0. Set w=0: never drawn.
- Write on the exact commit cycle: the old value is shown for one more frame; readback returns the new value after 1 cycle.
- Assert rst mid-line: the next cycle gives HS=VS=1, rgb=0, rdata=0, and the counters restart.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Shared definitions for the sprite display: bus field indices, the per-object
// record and the default 640x480@60 timing.
package vga_sprite_pkg;

    // Field selectors carried in addr[1:0]
    localparam logic [1:0] FLD_X    = 2'd0;
    localparam logic [1:0] FLD_Y    = 2'd1;
    localparam logic [1:0] FLD_SIZE = 2'd2;
    localparam logic [1:0] FLD_CTRL = 2'd3;

    // Default 640x480 timing (25 MHz pixel clock)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // One object; x/y are kept zero-extended to the 16-bit bus width
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  w;
        logic [7:0]  h;
        logic        en;
        logic [7:0]  rgb;
    } vga_obj_t;

    // Bus view of one field; unused bits read back as 0
    function automatic logic [15:0] obj_field_rd(input vga_obj_t o, input logic [1:0] fld);
        logic [15:0] v;
        case (fld)
            FLD_X:    v = o.x;
            FLD_Y:    v = o.y;
            FLD_SIZE: v = {o.h, o.w};
            FLD_CTRL: v = {7'd0, o.en, o.rgb};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters: h/v position, active-low syncs, active-area flag and
// the once-per-frame commit strobe at the last visible pixel.
module vga_timing_gen #(
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] o_h_cnt,
    output logic [COORD_W-1:0] o_v_cnt,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_active,
    output logic               o_commit
);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SY_BEG = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SY_END = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_SY_BEG = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SY_END = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;

    // Raster scan: h wraps every line, v advances on each h wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_hs     = !((r_h_cnt >= H_SY_BEG) && (r_h_cnt < H_SY_END));
    assign o_vs     = !((r_v_cnt >= V_SY_BEG) && (r_v_cnt < V_SY_END));
    assign o_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_commit = (r_h_cnt == H_ACT - 1'b1) && (r_v_cnt == V_ACT - 1'b1);

endmodule

// File: rtl/vga_sprite_engine.sv
// NUM_OBJ-sprite VGA display with a playfield border. CPU writes go to shadow
// registers that are copied to the displayed set at the last visible pixel.
// Optional build macro VGA_SPRITE_COLLISION_EN adds per-frame overlap flags.
module vga_sprite_engine
    import vga_sprite_pkg::*;
#(
    parameter int         NUM_OBJ    = 8,
    parameter int         COORD_W    = 10,
    parameter int         H_ACTIVE   = DEF_H_ACTIVE,
    parameter int         H_FRONT    = DEF_H_FRONT,
    parameter int         H_SYNC     = DEF_H_SYNC,
    parameter int         H_BACK     = DEF_H_BACK,
    parameter int         V_ACTIVE   = DEF_V_ACTIVE,
    parameter int         V_FRONT    = DEF_V_FRONT,
    parameter int         V_SYNC     = DEF_V_SYNC,
    parameter int         V_BACK     = DEF_V_BACK,
    parameter int         BORDER     = 10,
    parameter logic [7:0] BORDER_RGB = 8'b011_011_01
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel,
    input  logic                       we,
    input  logic [$clog2(NUM_OBJ)+1:0] addr,
    input  logic [15:0]                wdata,
    output logic [15:0]                rdata,
    output logic                       HS,
    output logic                       VS,
    output logic [2:0]                 red,
    output logic [2:0]                 green,
    output logic [1:0]                 blue,
    output logic                       frame_start,
    output logic [NUM_OBJ-1:0]         coll_status
);
    localparam int          AW    = $clog2(NUM_OBJ) + 2;
    localparam logic [15:0] CMASK = 16'((32'd1 << COORD_W) - 32'd1);
    localparam logic [COORD_W-1:0] B_LO  = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] B_HR  = COORD_W'(H_ACTIVE - BORDER);
    localparam logic [COORD_W-1:0] B_VB  = COORD_W'(V_ACTIVE - BORDER);

    vga_obj_t r_shd [NUM_OBJ];
    vga_obj_t r_act [NUM_OBJ];

    logic [AW-1:0]      w_idx;
    logic [15:0]        w_rd_val;
    logic [COORD_W-1:0] w_h_cnt, w_v_cnt;
    logic               w_hs, w_vs, w_active, w_commit, w_border;
    logic [16:0]        w_hc, w_vc;
    logic [NUM_OBJ-1:0] w_hit;
    logic [7:0]         w_obj_rgb;

    logic               r_active_p1, r_hs_p1, r_vs_p1, r_any_p1, r_border_p1;
    logic [7:0]         r_obj_rgb_p1;
    logic [7:0]         r_rgb_p2;

    vga_timing_gen #(
        .COORD_W (COORD_W),
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .o_h_cnt (w_h_cnt),
        .o_v_cnt (w_v_cnt),
        .o_hs    (w_hs),
        .o_vs    (w_vs),
        .o_active(w_active),
        .o_commit(w_commit)
    );

    assign w_idx       = addr >> 2;
    assign frame_start = w_commit & ~rst;

    // Shadow register file: bus writes, out-of-range indices never match
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBJ; i++) r_shd[i] <= '0;
        end else if (sel && we) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (w_idx == AW'(i)) begin
                    case (addr[1:0])
                        FLD_X:    r_shd[i].x <= wdata & CMASK;
                        FLD_Y:    r_shd[i].y <= wdata & CMASK;
                        FLD_SIZE: begin
                            r_shd[i].h <= wdata[15:8];
                            r_shd[i].w <= wdata[7:0];
                        end
                        FLD_CTRL: begin
                            r_shd[i].en  <= wdata[8];
                            r_shd[i].rgb <= wdata[7:0];
                        end
                    endcase
                end
            end
        end
    end

    // Read mux over shadows; out-of-range objects read as 0
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            if (w_idx == AW'(i)) w_rd_val = obj_field_rd(r_shd[i], addr[1:0]);
    end

    // Registered read port, holds its value between reads
    always_ff @(posedge clk) begin
        if (rst)              rdata <= '0;
        else if (sel && !we)  rdata <= w_rd_val;
    end

    // Frame commit: the last visible pixel still uses the old set; a write
    // landing on this same edge only reaches the shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBJ; i++) r_act[i] <= '0;
        end else if (w_commit) begin
            r_act <= r_shd;
        end
    end

    // Hit test in 17 bits so x+w can never wrap; lowest index wins
    always_comb begin
        w_hc      = 17'(w_h_cnt);
        w_vc      = 17'(w_v_cnt);
        w_hit     = '0;
        w_obj_rgb = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_hit[i] = w_active && r_act[i].en &&
                       (w_hc >= {1'b0, r_act[i].x}) && (w_hc < {1'b0, r_act[i].x} + 17'(r_act[i].w)) &&
                       (w_vc >= {1'b0, r_act[i].y}) && (w_vc < {1'b0, r_act[i].y} + 17'(r_act[i].h));
        end
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (w_hit[i]) w_obj_rgb = r_act[i].rgb;
    end

    assign w_border = (w_h_cnt < B_LO) || (w_h_cnt >= B_HR) ||
                      (w_v_cnt < B_LO) || (w_v_cnt >= B_VB);

    // ---- stage 1: hit / border / active, syncs delayed in step ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_p1 <= 1'b0;
            r_hs_p1     <= 1'b1;
            r_vs_p1     <= 1'b1;
        end else begin
            r_active_p1 <= w_active;
            r_hs_p1     <= w_hs;
            r_vs_p1     <= w_vs;
        end
    end

    // Stage 1 data path (no reset; qualified by r_active_p1)
    always_ff @(posedge clk) begin
        r_any_p1     <= |w_hit;
        r_obj_rgb_p1 <= w_obj_rgb;
        r_border_p1  <= w_border;
    end

    // ---- stage 2: colour mux, syncs aligned with rgb ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb_p2 <= '0;
            HS       <= 1'b1;
            VS       <= 1'b1;
        end else begin
            HS <= r_hs_p1;
            VS <= r_vs_p1;
            if (!r_active_p1)     r_rgb_p2 <= '0;
            else if (r_any_p1)    r_rgb_p2 <= r_obj_rgb_p1;
            else if (r_border_p1) r_rgb_p2 <= BORDER_RGB;
            else                  r_rgb_p2 <= '0;
        end
    end

    assign red   = r_rgb_p2[7:5];
    assign green = r_rgb_p2[4:2];
    assign blue  = r_rgb_p2[1:0];

`ifdef VGA_SPRITE_COLLISION_EN
    logic [NUM_OBJ-1:0] w_coll;
    logic [NUM_OBJ-1:0] r_coll_acc;

    // An object collides when it is hit together with any other object
    always_comb begin
        w_coll = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            w_coll[i] = w_hit[i] && ((w_hit & ~(NUM_OBJ'(1) << i)) != '0);
    end

    // Accumulate over the frame, publish at commit including the last pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coll_acc  <= '0;
            coll_status <= '0;
        end else if (w_commit) begin
            coll_status <= r_coll_acc | w_coll;
            r_coll_acc  <= '0;
        end else begin
            r_coll_acc  <= r_coll_acc | w_coll;
        end
    end
`else
    assign coll_status = '0;
`endif

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Scoreboard bench for vga_sprite_engine on a shrunken raster (48x31 total).
// The driver models the display at pixel level and queues expected outputs;
// a negedge monitor pops and compares them.
module tb_vga_sprite_engine;
    localparam int NUM_OBJ = 3;
    localparam int COORD_W = 8;
    localparam int HA = 32, HF = 4, HSY = 6, HB = 6;
    localparam int VA = 24, VF = 2, VSY = 2, VB = 3;
    localparam int BRD = 2;
    localparam logic [7:0] BRGB = 8'b011_011_01;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int COMMIT_POS = (VA - 1) * HT + HA - 1;
    localparam int AW = $clog2(NUM_OBJ) + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic HS, VS;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic frame_start;
    logic [NUM_OBJ-1:0] coll_status;

    vga_sprite_engine #(
        .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .BORDER(BRD), .BORDER_RGB(BRGB)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .HS(HS), .VS(VS), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .coll_status(coll_status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic [15:0] val;
    } exp_t;

    typedef struct packed {
        int x; int y; int w; int h; int en; int rgb;
    } mobj_t;

    exp_t pix_q[$];
    exp_t ctl_q[$];
    exp_t rd_q[$];

    mobj_t sh[NUM_OBJ];
    mobj_t ac[NUM_OBJ];
    logic [NUM_OBJ-1:0] m_acc, m_coll;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    function automatic bit m_hit(int i, int h, int v);
        return ac[i].en != 0 && h >= ac[i].x && h < ac[i].x + ac[i].w &&
               v >= ac[i].y && v < ac[i].y + ac[i].h;
    endfunction

    function automatic logic [7:0] m_pixel(int h, int v);
        if (h >= HA || v >= VA) return 8'h00;
        for (int i = 0; i < NUM_OBJ; i++)
            if (m_hit(i, h, v)) return ac[i].rgb[7:0];
        if (h < BRD || h >= HA - BRD || v < BRD || v >= VA - BRD) return BRGB;
        return 8'h00;
    endfunction

    function automatic logic [NUM_OBJ-1:0] m_overlap(int h, int v);
        logic [NUM_OBJ-1:0] m;
        int n;
        m = '0;
        n = 0;
        if (h < HA && v < VA)
            for (int i = 0; i < NUM_OBJ; i++)
                if (m_hit(i, h, v)) begin m[i] = 1'b1; n++; end
        return (n > 1) ? m : '0;
    endfunction

    function automatic logic [15:0] m_read(int idx, int fld);
        if (idx >= NUM_OBJ) return 16'h0;
        case (fld)
            0: return 16'(sh[idx].x);
            1: return 16'(sh[idx].y);
            2: return 16'((sh[idx].h << 8) | sh[idx].w);
            default: return 16'((sh[idx].en << 8) | sh[idx].rgb);
        endcase
    endfunction

    task automatic m_write(int idx, int fld, logic [15:0] d);
        if (idx >= NUM_OBJ) return;
        case (fld)
            0: sh[idx].x = d % (1 << COORD_W);
            1: sh[idx].y = d % (1 << COORD_W);
            2: begin sh[idx].h = d / 256; sh[idx].w = d % 256; end
            default: begin sh[idx].en = (d / 256) % 2; sh[idx].rgb = d % 256; end
        endcase
    endtask

    // ---------------- driver: one call per clock interval ----------------
    task automatic step(input bit wr, input bit rd, input int idx, input int fld, input logic [15:0] d);
        int pos, h, v;
        bit hs, vs;
        exp_t e;
        logic [NUM_OBJ-1:0] ov;
        pos = cyc % FRAME;
        h = pos % HT;
        v = pos / HT;
        hs = !(h >= HA + HF && h < HA + HF + HSY);
        vs = !(v >= VA + VF && v < VA + VF + VSY);
        e.due = 32'(cyc + 2);
        e.val = {6'd0, hs, vs, m_pixel(h, v)};
        pix_q.push_back(e);
        e.due = 32'(cyc);
        e.val = 16'({m_coll, (pos == COMMIT_POS)});
        ctl_q.push_back(e);
        sel = wr | rd;
        we = wr;
        addr = AW'(idx * 4 + fld);
        wdata = d;
        if (rd && !wr) begin
            e.due = 32'(cyc + 1);
            e.val = m_read(idx, fld);
            rd_q.push_back(e);
        end
        ov = m_overlap(h, v);
        if (pos == COMMIT_POS) begin
`ifdef VGA_SPRITE_COLLISION_EN
            m_coll = m_acc | ov;
`endif
            m_acc = '0;
            ac = sh;
        end else begin
            m_acc = m_acc | ov;
        end
        if (wr) m_write(idx, fld, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 16'h0);
    endtask

    task automatic wr_obj(int idx, int fld, logic [15:0] d);
        step(1'b1, 1'b0, idx, fld, d);
    endtask

    task automatic rd_obj(int idx, int fld);
        step(1'b0, 1'b1, idx, fld, 16'h0);
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        sel = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pix_q.delete();
        ctl_q.delete();
        rd_q.delete();
        for (int i = 0; i < NUM_OBJ; i++) begin sh[i] = '0; ac[i] = '0; end
        m_acc = '0;
        m_coll = '0;
        e.val = {6'd0, 1'b1, 1'b1, 8'h00};
        e.due = 0; pix_q.push_back(e);
        e.due = 1; pix_q.push_back(e);
        e.due = 0; e.val = 16'h0; rd_q.push_back(e);
    endtask

    task automatic rand_op();
        int idx, fld, kind;
        logic [15:0] d, junk;
        idx = $urandom_range(0, 3);
        fld = $urandom_range(0, 3);
        kind = $urandom_range(0, 3);
        junk = 16'($urandom);
        case (fld)
            0: d = {junk[15:8], 8'($urandom_range(0, HA + 6))};
            1: d = {junk[15:8], 8'($urandom_range(0, VA + 4))};
            2: d = {8'($urandom_range(0, 10)), ($urandom_range(0, 7) == 0) ? 8'd250 : 8'($urandom_range(0, 20))};
            default: d = {junk[15:9], 1'($urandom_range(0, 3) != 0), 8'($urandom)};
        endcase
        if (kind == 0) rd_obj(idx, fld);
        else           wr_obj(idx, fld, d);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        while (pix_q.size() > 0 && int'(pix_q[0].due) <= cyc) begin
            e = pix_q.pop_front();
            checks++;
            if (int'(e.due) != cyc || {HS, VS, red, green, blue} !== e.val[9:0]) begin
                failures++;
                $display("FAIL pixel cyc=%0d due=%0d got hs/vs/rgb=%b_%b_%h required=%b_%b_%h",
                         cyc, e.due, HS, VS, {red, green, blue}, e.val[9], e.val[8], e.val[7:0]);
            end
        end
        while (ctl_q.size() > 0 && int'(ctl_q[0].due) <= cyc) begin
            e = ctl_q.pop_front();
            checks++;
            if (int'(e.due) != cyc || {coll_status, frame_start} !== e.val[NUM_OBJ:0]) begin
                failures++;
                $display("FAIL frame_ctl cyc=%0d got coll=%b fs=%b required coll=%b fs=%b",
                         cyc, coll_status, frame_start, e.val[NUM_OBJ:1], e.val[0]);
            end
        end
        while (rd_q.size() > 0 && int'(rd_q[0].due) <= cyc) begin
            e = rd_q.pop_front();
            checks++;
            if (int'(e.due) != cyc || rdata !== e.val) begin
                failures++;
                $display("FAIL rdata cyc=%0d got=%h required=%h", cyc, rdata, e.val);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        idle(FRAME + 20);

        // obj0 red square written mid-frame, shown from the next frame
        wr_obj(0, 0, 16'd10);
        wr_obj(0, 1, 16'd5);
        wr_obj(0, 2, 16'h0406);
        wr_obj(0, 3, 16'h01E0);
        rd_obj(0, 0); rd_obj(0, 2); rd_obj(0, 3);
        idle(2 * FRAME);

        // obj1 overlapping at the same origin; obj0 keeps priority
        wr_obj(1, 0, 16'd10);
        wr_obj(1, 1, 16'd5);
        wr_obj(1, 2, 16'h0304);
        wr_obj(1, 3, 16'h0103);
        idle(2 * FRAME);

        // obj2 wide object clipped at the right edge, then zero width
        wr_obj(2, 0, 16'd28);
        wr_obj(2, 1, 16'd12);
        wr_obj(2, 2, 16'h03FA);
        wr_obj(2, 3, 16'h011C);
        idle(2 * FRAME);
        wr_obj(2, 2, 16'h0300);
        rd_obj(2, 2);
        idle(2 * FRAME);

        // out-of-range object index: write dropped, reads 0; junk upper bits masked
        wr_obj(3, 0, 16'h1234);
        rd_obj(3, 0);
        wr_obj(1, 0, 16'hFF0C);
        rd_obj(1, 0);

        // write landing exactly on the commit cycle
        while (cyc % FRAME != COMMIT_POS) idle(1);
        wr_obj(0, 0, 16'd20);
        rd_obj(0, 0);
        idle(2 * FRAME);

        // randomized bus traffic
        for (int n = 0; n < 300; n++) begin
            rand_op();
            idle($urandom_range(0, 30));
        end
        idle(FRAME);

        // reset in the middle of a visible line
        while ((cyc % FRAME) != 10 * HT + 17) idle(1);
        do_reset();
        idle(FRAME + 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
